axis_fir_coef_scheduler: RTL and testbench

- Runtime coefficient manager for the AXI-Stream FIR cores (symmetric and plain variants).
- Accepts a serial coefficient frame on an AXI-Stream slave and stages it in a shadow bank.
- Commits the shadow bank to the active bank atomically, on a sample boundary of the FIR input stream, so the filter never computes one sample with mixed old and new taps.
- The active bank drives the FIR b0..bN ports through a flat bus.

---
 rtl/axis_fir_coef_scheduler.sv | 118 +++++++++++
 tb/tb_axis_fir_coef_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fir_coef_scheduler.sv
// Runtime coefficient manager for the AXI-Stream FIR cores: stages a serial
// coefficient frame in a shadow bank and commits it atomically to the active bank.
module axis_fir_coef_scheduler #(
  parameter int unsigned NTAPS          = 17,
  parameter int unsigned COEF_WIDTH     = 24,
  parameter bit          SWAP_ON_SAMPLE = 1'b1
) (
  input  logic                        aclk,
  input  logic                        resetn,
  input  logic [COEF_WIDTH-1:0]       s_axis_coef_tdata,
  input  logic                        s_axis_coef_tvalid,
  output logic                        s_axis_coef_tready,
  input  logic                        s_axis_coef_tlast,
  input  logic                        fir_tvalid,
  input  logic                        fir_tready,
  output logic [NTAPS*COEF_WIDTH-1:0] coef_bus,
  output logic                        coef_update,
  output logic                        swap_pending,
  output logic                        load_error,
  output logic [7:0]                  frame_count
);

  localparam int unsigned IW = $clog2(NTAPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DISCARD, S_PENDING} state_t;

  state_t                               r_state;
  logic [IW-1:0]                        r_idx;
  logic [NTAPS-1:0][COEF_WIDTH-1:0]     r_shadow;
  logic [NTAPS-1:0][COEF_WIDTH-1:0]     r_active;
  logic                                 r_tready;
  logic                                 r_coef_update;
  logic                                 r_swap_pending;
  logic                                 r_load_error;
  logic [7:0]                           r_frame_count;

  logic w_accept;
  logic w_commit;

  assign w_accept = s_axis_coef_tvalid & r_tready;
  // With sample-boundary swapping the FIR consumes its current sample with the
  // old taps on the commit edge; new taps apply from the next handshake.
  assign w_commit = SWAP_ON_SAMPLE ? (fir_tvalid & fir_tready) : 1'b1;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_shadow       <= '0;
      r_active       <= '0;
      r_tready       <= 1'b0;
      r_coef_update  <= 1'b0;
      r_swap_pending <= 1'b0;
      r_load_error   <= 1'b0;
      r_frame_count  <= '0;
    end else begin
      r_coef_update <= 1'b0;
      r_tready      <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shadow[0] <= s_axis_coef_tdata;
            if (s_axis_coef_tlast) begin
              r_load_error <= 1'b1;
            end else begin
              r_idx   <= IW'(1);
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_shadow[r_idx] <= s_axis_coef_tdata;
            if (r_idx == LAST_IDX) begin
              if (s_axis_coef_tlast) begin
                r_state        <= S_PENDING;
                r_swap_pending <= 1'b1;
                r_tready       <= 1'b0;
              end else begin
                r_load_error <= 1'b1;
                r_state      <= S_DISCARD;
              end
            end else if (s_axis_coef_tlast) begin
              r_load_error <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        S_DISCARD: begin
          if (w_accept && s_axis_coef_tlast) r_state <= S_IDLE;
        end
        S_PENDING: begin
          r_tready <= w_commit;
          if (w_commit) begin
            r_active       <= r_shadow;
            r_swap_pending <= 1'b0;
            r_load_error   <= 1'b0;
            r_frame_count  <= r_frame_count + 8'd1;
            r_coef_update  <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_axis_coef_tready = r_tready;
  assign coef_bus           = r_active;
  assign coef_update        = r_coef_update;
  assign swap_pending       = r_swap_pending;
  assign load_error         = r_load_error;
  assign frame_count        = r_frame_count;

endmodule

// File: tb/tb_axis_fir_coef_scheduler.sv
// Scoreboard bench for axis_fir_coef_scheduler: commits are predicted into a
// queue and checked by a monitor on each coef_update pulse.
module tb_axis_fir_coef_scheduler;

  localparam int NT = 17;
  localparam int CW = 24;
  localparam int BW = NT * CW;

  logic          aclk;
  logic          resetn;
  logic [CW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          sel1;
  logic          fir_v;
  logic          fir_r;

  logic          tready0, upd0, pend0, err0;
  logic [BW-1:0] bus0;
  logic [7:0]    cnt0;
  logic          tready1, upd1, pend1, err1;
  logic [BW-1:0] bus1;
  logic [7:0]    cnt1;

  axis_fir_coef_scheduler #(.NTAPS(NT), .COEF_WIDTH(CW), .SWAP_ON_SAMPLE(1'b1)) u_dut (
    .aclk(aclk), .resetn(resetn),
    .s_axis_coef_tdata(tdata), .s_axis_coef_tvalid(tvalid & ~sel1),
    .s_axis_coef_tready(tready0), .s_axis_coef_tlast(tlast),
    .fir_tvalid(fir_v), .fir_tready(fir_r),
    .coef_bus(bus0), .coef_update(upd0), .swap_pending(pend0),
    .load_error(err0), .frame_count(cnt0)
  );

  axis_fir_coef_scheduler #(.NTAPS(NT), .COEF_WIDTH(CW), .SWAP_ON_SAMPLE(1'b0)) u_dut_nosample (
    .aclk(aclk), .resetn(resetn),
    .s_axis_coef_tdata(tdata), .s_axis_coef_tvalid(tvalid & sel1),
    .s_axis_coef_tready(tready1), .s_axis_coef_tlast(tlast),
    .fir_tvalid(fir_v), .fir_tready(fir_r),
    .coef_bus(bus1), .coef_update(upd1), .swap_pending(pend1),
    .load_error(err1), .frame_count(cnt1)
  );

  typedef struct {
    logic [BW-1:0] bus;
    logic [7:0]    cnt;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] fw [20];

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack_fw();
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < NT; k++) b[k*CW +: CW] = fw[k];
    return b;
  endfunction

  task automatic fill_fw(input logic [CW-1:0] base, input logic [CW-1:0] step);
    for (int k = 0; k < 20; k++) fw[k] = base + CW'(k) * step;
  endtask

  task automatic send(input logic [CW-1:0] d, input logic last);
    int n;
    tdata  = d;
    tlast  = last;
    tvalid = 1'b1;
    n = 0;
    while (((sel1 ? tready1 : tready0) !== 1'b1) && n < 50) begin
      @(posedge aclk); #1;
      n++;
    end
    if (n >= 50) chk("tready_timeout", 1'b0, 1'b1);
    @(posedge aclk); #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_fw(input int n);
    for (int k = 0; k < n; k++) send(fw[k], (k == n - 1));
  endtask

  task automatic commit_expect(input logic [7:0] cnt);
    exp_t e;
    e.bus = pack_fw();
    e.cnt = cnt;
    sb_q.push_back(e);
    fir_v = 1'b1;
    fir_r = 1'b1;
    @(posedge aclk); #1;
    fir_v = 1'b0;
    fir_r = 1'b0;
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    #1;
    chk("rst_bus",   bus0,    '0);
    chk("rst_pend",  pend0,   '0);
    chk("rst_tready", tready0, '0);
    chk("rst_err",   err0,    '0);
    chk("rst_cnt",   cnt0,    '0);
    chk("rst_upd",   upd0,    '0);
    @(posedge aclk); #1;
    resetn = 1'b1;
  endtask

  // Monitor: every coef_update must match the next predicted commit.
  initial begin
    logic [BW-1:0] prev_bus;
    logic          prev_upd;
    exp_t          e;
    prev_bus = '0;
    prev_upd = 1'b0;
    forever begin
      @(negedge aclk);
      if (!resetn) begin
        prev_bus = bus0;
        prev_upd = 1'b0;
      end else begin
        if (bus0 !== prev_bus) chk("bus_change_with_update", upd0, 1'b1);
        if (upd0 === 1'b1) begin
          chk("update_single_cycle", prev_upd, 1'b0);
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_update: got coef_update=1 expected no commit, bus %0h", bus0);
          end else begin
            e = sb_q.pop_front();
            chk("sb_bus", bus0, e.bus);
            chk("sb_cnt", cnt0, e.cnt);
          end
        end
        prev_bus = bus0;
        prev_upd = upd0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] bus_hold;
    resetn = 1'b0;
    tdata  = '0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    sel1   = 1'b0;
    fir_v  = 1'b0;
    fir_r  = 1'b0;
    #1;
    chk("reset_bus",    bus0,    '0);
    chk("reset_tready", tready0, '0);
    chk("reset_cnt",    cnt0,    '0);
    repeat (2) @(posedge aclk);
    #1;
    resetn = 1'b1;

    fill_fw(24'd224240, 24'd2931);
    fw[16] = 24'd271151;
    send_fw(17);
    chk("f1_pending", pend0,   1'b1);
    chk("f1_tready",  tready0, 1'b0);
    chk("f1_bus_old", bus0,    '0);
    repeat (3) @(posedge aclk);
    #1;
    chk("f1_still_pending", pend0, 1'b1);
    chk("f1_still_old",     bus0,  '0);
    commit_expect(8'd1);
    chk("f1_b0",   bus0[23:0],    24'd224240);
    chk("f1_b16",  bus0[407:384], 24'd271151);
    chk("f1_cnt",  cnt0,          8'd1);
    chk("f1_pend_clr", pend0,     1'b0);
    bus_hold = bus0;

    fir_v = 1'b1;
    fir_r = 1'b1;
    fill_fw(24'd100, 24'd1);
    send_fw(5);
    fir_v = 1'b0;
    fir_r = 1'b0;
    chk("short_err",    err0,    1'b1);
    chk("short_nopend", pend0,   1'b0);
    chk("short_bus",    bus0,    bus_hold);
    chk("short_tready", tready0, 1'b1);

    fill_fw(24'hFFF000, 24'h000101);
    send_fw(17);
    commit_expect(8'd2);
    chk("f2_err_clr", err0, 1'b0);
    chk("f2_cnt",     cnt0, 8'd2);

    send(24'h123456, 1'b1);
    chk("one_word_err", err0, 1'b1);
    fill_fw(24'h7FFF00, 24'hFFFFF1);
    send_fw(17);
    commit_expect(8'd3);
    chk("f3_err_clr", err0, 1'b0);
    bus_hold = bus0;

    fill_fw(24'h000AAA, 24'h000010);
    for (int k = 0; k < 20; k++) begin
      chk("long_tready", tready0, 1'b1);
      send(fw[k], (k == 19));
    end
    chk("long_err",    err0,  1'b1);
    chk("long_nopend", pend0, 1'b0);
    chk("long_bus",    bus0,  bus_hold);

    fill_fw(24'h55AA00, 24'h000003);
    send_fw(17);
    commit_expect(8'd4);

    fill_fw(24'h300000, 24'h000100);
    for (int k = 0; k < 10; k++) send(fw[k], 1'b0);
    pulse_reset();
    fill_fw(24'h400000, 24'h000777);
    send_fw(17);
    commit_expect(8'd1);

    send_fw(17);
    chk("pend_before_reset", pend0, 1'b1);
    pulse_reset();
    fill_fw(24'h0C0C0C, 24'h001001);
    send_fw(17);
    commit_expect(8'd1);

    sel1 = 1'b1;
    fill_fw(24'h654321, 24'h000013);
    send_fw(17);
    chk("ns_pending", pend1, 1'b1);
    chk("ns_bus_old", bus1,  '0);
    @(posedge aclk); #1;
    chk("ns_bus",      bus1,  pack_fw());
    chk("ns_pend_clr", pend1, 1'b0);
    chk("ns_upd",      upd1,  1'b1);
    chk("ns_cnt",      cnt1,  8'd1);
    @(posedge aclk); #1;
    chk("ns_upd_drop", upd1,  1'b0);
    sel1 = 1'b0;

    repeat (3) @(posedge aclk);
    #1;
    chk("sb_drained", BW'(sb_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
